// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with dual-CDB operand snooping and lowest-index dispatch
`ifndef ROB_SZ_LOG
`define ROB_SZ_LOG 4
`endif
module alu_rs #(
   parameter int RS_SZ_LOG = 3,
   parameter int TAG_W = `ROB_SZ_LOG + 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             clr_in,
   input  logic             issue_vld,
   input  logic [3:0]       issue_opcode,
   input  logic [31:0]      issue_Vj,
   input  logic [31:0]      issue_Vk,
   input  logic             issue_Qj_busy,
   input  logic             issue_Qk_busy,
   input  logic [TAG_W-1:0] issue_Qj,
   input  logic [TAG_W-1:0] issue_Qk,
   input  logic [31:0]      issue_imm,
   input  logic [31:0]      issue_pc,
   input  logic [TAG_W-1:0] issue_rd,
   input  logic             alu_cdb_vld,
   input  logic [TAG_W-1:0] alu_cdb_tag,
   input  logic [31:0]      alu_cdb_val,
   input  logic             lsb_cdb_vld,
   input  logic [TAG_W-1:0] lsb_cdb_tag,
   input  logic [31:0]      lsb_cdb_val,
   output logic             full_out,
   output logic             run_flg_out,
   output logic [TAG_W-1:0] rd_out,
   output logic [31:0]      Vj_out,
   output logic [31:0]      Vk_out,
   output logic [31:0]      imm_out,
   output logic [31:0]      pc_out,
   output logic [3:0]       opcode_out
);
   localparam int N = 1 << RS_SZ_LOG;
   typedef struct packed {
      logic             busy;
      logic [3:0]       op;
      logic [31:0]      vj;
      logic [31:0]      vk;
      logic             qjb;
      logic [TAG_W-1:0] qj;
      logic             qkb;
      logic [TAG_W-1:0] qk;
      logic [31:0]      imm;
      logic [31:0]      pc;
      logic [TAG_W-1:0] rd;
   } ent_t;
   ent_t rs [N];
   logic [N-1:0] busy, rdy;
   logic [RS_SZ_LOG-1:0] sel, fre;
   logic has_sel;
   // {still_waiting, value}; the ALU port wins when both ports carry the tag
   function automatic logic [32:0] snoop(input logic b, input logic [TAG_W-1:0] q, input logic [31:0] v);
      return (b && alu_cdb_vld && alu_cdb_tag == q) ? {1'b0, alu_cdb_val} :
             (b && lsb_cdb_vld && lsb_cdb_tag == q) ? {1'b0, lsb_cdb_val} : {b, v};
   endfunction
   always_comb begin
      busy = '0;
      rdy = '0;
      sel = '0;
      fre = '0;
      for (int i = N - 1; i >= 0; i--) begin
         busy[i] = rs[i].busy;
         rdy[i] = rs[i].busy && !rs[i].qjb && !rs[i].qkb;
         if (rdy[i]) sel = RS_SZ_LOG'(i);
         if (!rs[i].busy) fre = RS_SZ_LOG'(i);
      end
   end
   assign has_sel = |rdy;
   assign full_out = &busy;
   always_ff @(posedge clk_in) begin
      if (!rst_in || clr_in) begin
         for (int i = 0; i < N; i++) rs[i].busy <= 1'b0;
         run_flg_out <= 1'b0;
         if (!rst_in) {rd_out, Vj_out, Vk_out, imm_out, pc_out, opcode_out} <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (rs[i].busy) begin
               {rs[i].qjb, rs[i].vj} <= snoop(rs[i].qjb, rs[i].qj, rs[i].vj);
               {rs[i].qkb, rs[i].vk} <= snoop(rs[i].qkb, rs[i].qk, rs[i].vk);
            end
         run_flg_out <= has_sel;
         if (has_sel) begin
            rs[sel].busy <= 1'b0;
            rd_out <= rs[sel].rd;
            Vj_out <= rs[sel].vj;
            Vk_out <= rs[sel].vk;
            imm_out <= rs[sel].imm;
            pc_out <= rs[sel].pc;
            opcode_out <= rs[sel].op;
         end
         // fre comes from registered busy, so a slot freed this edge is never refilled now
         if (issue_vld && !full_out) begin
            rs[fre].busy <= 1'b1;
            rs[fre].op <= issue_opcode;
            rs[fre].qj <= issue_Qj;
            rs[fre].qk <= issue_Qk;
            rs[fre].imm <= issue_imm;
            rs[fre].pc <= issue_pc;
            rs[fre].rd <= issue_rd;
            {rs[fre].qjb, rs[fre].vj} <= snoop(issue_Qj_busy, issue_Qj, issue_Vj);
            {rs[fre].qkb, rs[fre].vk} <= snoop(issue_Qk_busy, issue_Qk, issue_Vk);
         end
      end
   end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed and random checks of alu_rs against a slot-level behavioural model
`ifndef ADD
`define ADD 4'd0
`endif
`ifndef SUB
`define SUB 4'd1
`endif
module tb_alu_rs;
   localparam int N = 8;
   localparam int TW = 5;
   logic clk_in = 1'b0;
   logic rst_in, clr_in, issue_vld, issue_Qj_busy, issue_Qk_busy;
   logic [3:0] issue_opcode;
   logic [31:0] issue_Vj, issue_Vk, issue_imm, issue_pc, alu_cdb_val, lsb_cdb_val;
   logic [TW-1:0] issue_Qj, issue_Qk, issue_rd, alu_cdb_tag, lsb_cdb_tag;
   logic alu_cdb_vld, lsb_cdb_vld;
   logic full_out, run_flg_out;
   logic [TW-1:0] rd_out;
   logic [31:0] Vj_out, Vk_out, imm_out, pc_out;
   logic [3:0] opcode_out;
   always #5 clk_in = ~clk_in;
   alu_rs #(.RS_SZ_LOG(3), .TAG_W(TW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .clr_in(clr_in),
      .issue_vld(issue_vld), .issue_opcode(issue_opcode),
      .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
      .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
      .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rd(issue_rd),
      .alu_cdb_vld(alu_cdb_vld), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
      .lsb_cdb_vld(lsb_cdb_vld), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
      .full_out(full_out), .run_flg_out(run_flg_out), .rd_out(rd_out),
      .Vj_out(Vj_out), .Vk_out(Vk_out), .imm_out(imm_out), .pc_out(pc_out),
      .opcode_out(opcode_out)
   );
   typedef struct {
      bit busy, jw, kw;
      logic [3:0] op;
      logic [31:0] vj, vk, imm, pc;
      logic [TW-1:0] qj, qk, rd;
   } slot_t;
   slot_t m [N];
   bit e_run, started;
   logic [TW-1:0] e_rd;
   logic [31:0] e_vj, e_vk, e_imm, e_pc;
   logic [3:0] e_op;
   int n_chk = 0, n_fail = 0;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic bit model_full();
      foreach (m[i]) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction
   function automatic void resolve(input bit w, input logic [TW-1:0] q, input logic [31:0] v,
                                   output bit wo, output logic [31:0] vo);
      wo = w;
      vo = v;
      if (w && alu_cdb_vld && alu_cdb_tag == q) begin wo = 0; vo = alu_cdb_val; end
      else if (w && lsb_cdb_vld && lsb_cdb_tag == q) begin wo = 0; vo = lsb_cdb_val; end
   endfunction
   task automatic model_edge();
      int pick = -1, fr = -1;
      bit full = model_full();
      foreach (m[i]) begin
         if (pick < 0 && m[i].busy && !m[i].jw && !m[i].kw) pick = i;
         if (fr < 0 && !m[i].busy) fr = i;
      end
      if (!rst_in || clr_in) begin
         foreach (m[i]) m[i].busy = 0;
         e_run = 0;
         if (!rst_in) begin
            e_rd = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_pc = '0; e_op = '0;
         end
      end else begin
         e_run = pick >= 0;
         if (pick >= 0) begin
            e_rd = m[pick].rd; e_vj = m[pick].vj; e_vk = m[pick].vk;
            e_imm = m[pick].imm; e_pc = m[pick].pc; e_op = m[pick].op;
            m[pick].busy = 0;
         end
         foreach (m[i]) if (m[i].busy) begin
            resolve(m[i].jw, m[i].qj, m[i].vj, m[i].jw, m[i].vj);
            resolve(m[i].kw, m[i].qk, m[i].vk, m[i].kw, m[i].vk);
         end
         if (issue_vld && !full) begin
            m[fr].busy = 1;
            m[fr].op = issue_opcode; m[fr].imm = issue_imm; m[fr].pc = issue_pc;
            m[fr].rd = issue_rd; m[fr].qj = issue_Qj; m[fr].qk = issue_Qk;
            resolve(issue_Qj_busy, issue_Qj, issue_Vj, m[fr].jw, m[fr].vj);
            resolve(issue_Qk_busy, issue_Qk, issue_Vk, m[fr].kw, m[fr].vk);
         end
      end
   endtask
   task automatic tick();
      if (started) check("full", full_out, model_full());
      model_edge();
      @(posedge clk_in);
      #1;
      started = 1;
      check("run", run_flg_out, e_run);
      check("rd", rd_out, e_rd);
      check("vj", Vj_out, e_vj);
      check("vk", Vk_out, e_vk);
      check("imm", imm_out, e_imm);
      check("pc", pc_out, e_pc);
      check("op", opcode_out, e_op);
   endtask
   task automatic idle();
      rst_in = 1; clr_in = 0; issue_vld = 0;
      alu_cdb_vld = 0; lsb_cdb_vld = 0;
   endtask
   task automatic iss(input logic [3:0] op, input logic [31:0] vj, vk, input bit jb,
                      input int qj, input bit kb, input int qk, input int rd);
      issue_vld = 1; issue_opcode = op; issue_Vj = vj; issue_Vk = vk;
      issue_Qj_busy = jb; issue_Qj = TW'(qj); issue_Qk_busy = kb; issue_Qk = TW'(qk);
      issue_imm = 32'h1000 + 32'(rd); issue_pc = 32'h8000 + 32'(rd * 4); issue_rd = TW'(rd);
   endtask
   initial begin
      idle();
      alu_cdb_tag = '0; alu_cdb_val = '0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
      rst_in = 0;
      iss(`ADD, 32'd9, 32'd9, 0, 0, 0, 0, 7);
      tick();
      tick();
      check("rst_run", run_flg_out, 0);
      check("rst_vj", Vj_out, 0);
      check("rst_full", full_out, 0);
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_idle", run_flg_out, 0);
      end
      iss(`ADD, 32'd5, 32'd7, 0, 0, 0, 0, 3);
      tick();
      check("ready_k", run_flg_out, 0);
      idle();
      tick();
      check("ready_run", run_flg_out, 1);
      check("ready_vj", Vj_out, 5);
      check("ready_vk", Vk_out, 7);
      check("ready_rd", rd_out, 3);
      check("ready_op", opcode_out, `ADD);
      tick();
      check("ready_once", run_flg_out, 0);
      iss(`SUB, 32'd0, 32'd1, 1, 2, 0, 0, 5);
      tick();
      idle();
      tick();
      tick();
      alu_cdb_vld = 1; alu_cdb_tag = 5'd2; alu_cdb_val = 32'h10;
      tick();
      check("wake_early", run_flg_out, 0);
      idle();
      tick();
      check("wake_run", run_flg_out, 1);
      check("wake_vj", Vj_out, 32'h10);
      check("wake_vk", Vk_out, 1);
      iss(`ADD, 32'd3, 32'd0, 0, 0, 1, 4, 6);
      lsb_cdb_vld = 1; lsb_cdb_tag = 5'd4; lsb_cdb_val = 32'hABCD;
      tick();
      idle();
      tick();
      check("byp_run", run_flg_out, 1);
      check("byp_vk", Vk_out, 32'hABCD);
      iss(`ADD, 32'd3, 32'd0, 0, 0, 1, 4, 7);
      alu_cdb_vld = 1; alu_cdb_tag = 5'd4; alu_cdb_val = 32'd1;
      lsb_cdb_vld = 1; lsb_cdb_tag = 5'd4; lsb_cdb_val = 32'd2;
      tick();
      idle();
      tick();
      check("byp2_run", run_flg_out, 1);
      check("byp2_vk", Vk_out, 1);
      for (int i = 0; i < N; i++) begin
         iss(`ADD, 32'd0, 32'(i), 1, 9, 0, 0, i);
         tick();
      end
      check("full_set", full_out, 1);
      iss(`SUB, 32'd0, 32'd0, 0, 0, 0, 0, 20);
      tick();
      idle();
      alu_cdb_vld = 1; alu_cdb_tag = 5'd9; alu_cdb_val = 32'h99;
      tick();
      check("full_hold", full_out, 1);
      idle();
      for (int i = 0; i < N; i++) begin
         tick();
         check("drain_run", run_flg_out, 1);
         check("drain_rd", rd_out, i);
         check("drain_vj", Vj_out, 32'h99);
         if (i == 0) check("full_fall", full_out, 0);
      end
      tick();
      check("drop_gone", run_flg_out, 0);
      iss(`ADD, 32'd1, 32'd1, 0, 0, 0, 0, 1);
      tick();
      iss(`ADD, 32'd2, 32'd2, 0, 0, 0, 0, 2);
      tick();
      check("ord_run", run_flg_out, 1);
      check("ord_rd", rd_out, 1);
      iss(`ADD, 32'd3, 32'd3, 0, 0, 0, 0, 3);
      clr_in = 1;
      tick();
      check("clr_run", run_flg_out, 0);
      idle();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("clr_quiet", run_flg_out, 0);
      end
      for (int c = 0; c < 1500; c++) begin
         rst_in = $urandom_range(0, 199) != 0;
         clr_in = $urandom_range(0, 49) == 0;
         issue_vld = ($urandom_range(0, 2) != 0) && !model_full();
         issue_opcode = 4'($urandom_range(0, 15));
         issue_Vj = $urandom; issue_Vk = $urandom;
         issue_imm = $urandom; issue_pc = $urandom;
         issue_Qj_busy = 1'($urandom_range(0, 1)); issue_Qj = TW'($urandom_range(0, 7));
         issue_Qk_busy = 1'($urandom_range(0, 1)); issue_Qk = TW'($urandom_range(0, 7));
         issue_rd = TW'($urandom_range(0, 31));
         alu_cdb_vld = $urandom_range(0, 2) == 0; alu_cdb_tag = TW'($urandom_range(0, 7));
         alu_cdb_val = $urandom;
         lsb_cdb_vld = $urandom_range(0, 2) == 0; lsb_cdb_tag = TW'($urandom_range(0, 7));
         lsb_cdb_val = $urandom;
         tick();
      end
      idle();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
